// File: rtl/mem_pkg.sv
// Shared encodings for the data memory unit: transfer sizes, MMIO register
// offsets, STATUS bit positions and the size decode helper.
package mem_pkg;

   localparam logic [2:0] MT_B  = 3'b000;
   localparam logic [2:0] MT_H  = 3'b001;
   localparam logic [2:0] MT_W  = 3'b010;
   localparam logic [2:0] MT_BU = 3'b100;
   localparam logic [2:0] MT_HU = 3'b101;

   localparam logic [3:0] OFF_TX     = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLE  = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_CNT   = 3;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

   // Sign handling lives in the core, so B/BU and H/HU share a lane size.
   function automatic size_e size_of(input logic [2:0] mt);
      case (mt)
         MT_B, MT_BU: size_of = SZ_B;
         MT_H, MT_HU: size_of = SZ_H;
         MT_W:        size_of = SZ_W;
         default:     size_of = SZ_BAD;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Core-side memory port plus the TX drain port of the data memory unit.
interface data_mem_unit_if;
   logic [31:0] MEM_addr;
   logic [31:0] MEM_WR_out;
   logic [2:0]  MEM_type;
   logic        MEM_rd_en;
   logic        MEM_wr_en;
   logic [31:0] MEM_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        misalign_err;

   modport master (
      output MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en, tx_ready,
      input  MEM_data, tx_data, tx_valid, misalign_err
   );

   modport slave (
      input  MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en, tx_ready,
      output MEM_data, tx_data, tx_valid, misalign_err
   );
endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX drain port; a push on full is accepted only when
// a pop frees the head slot in the same cycle, otherwise it sets a sticky overflow.
module tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_req,
   input  logic [7:0]               push_data,
   input  logic                     pop_ready,
   input  logic                     ovf_clr,
   output logic [7:0]               head,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   logic          full_s, empty_s, pop_s, push_s;

   // Flow control from the current occupancy.
   always_comb begin
      full_s  = (count_r == CW'(DEPTH));
      empty_s = (count_r == {CW{1'b0}});
      pop_s   = ~empty_s & pop_ready;
      push_s  = push_req & (~full_s | pop_s);
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (push_req & full_s & ~pop_s) overflow_r <= 1'b1;
         else if (ovf_clr)               overflow_r <= 1'b0;
      end
   end

   // Byte storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign head     = empty_s ? 8'h00 : mem_r[rd_ptr_r];
   assign valid    = ~empty_s;
   assign full     = full_s;
   assign empty    = empty_s;
   assign count    = count_r;
   assign overflow = overflow_r;
endmodule

// File: rtl/data_mem_unit.sv
// Data-side memory block: byte-lane word RAM plus an MMIO page holding the TX
// FIFO, STATUS and a free-running cycle counter. Load data is combinational.
module data_mem_unit
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input  logic            CLK,
   input  logic            Reset,
   data_mem_unit_if.slave  bus
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

   logic [31:0]   ram_r [DEPTH_WORDS];
   logic [31:0]   cycle_r;
   logic          misalign_r;

   size_e         size_s;
   logic          access_s, aligned_s, ok_s, err_s;
   logic          in_ram_s, in_mmio_s, mmio_word_s;
   logic          ram_we_s, tx_push_s, ctrl_we_s;
   logic [3:0]    be_s;
   logic [31:0]   wdata_s, word_s, rdata_s, status_s;
   logic [AW-1:0] idx_s;
   logic [7:0]    tx_head_s;
   logic          tx_valid_s, fifo_full_s, fifo_empty_s, fifo_ovf_s;
   logic [CW-1:0] fifo_count_s;

   // Size/alignment decode, lane enables and region select.
   always_comb begin
      size_s   = size_of(bus.MEM_type);
      access_s = bus.MEM_rd_en | bus.MEM_wr_en;
      case (size_s)
         SZ_B: begin
            aligned_s = 1'b1;
            be_s      = 4'b0001 << bus.MEM_addr[1:0];
            wdata_s   = {4{bus.MEM_WR_out[7:0]}};
         end
         SZ_H: begin
            aligned_s = ~bus.MEM_addr[0];
            be_s      = 4'b0011 << {bus.MEM_addr[1], 1'b0};
            wdata_s   = {2{bus.MEM_WR_out[15:0]}};
         end
         SZ_W: begin
            aligned_s = (bus.MEM_addr[1:0] == 2'b00);
            be_s      = 4'b1111;
            wdata_s   = bus.MEM_WR_out;
         end
         default: begin
            aligned_s = 1'b0;
            be_s      = 4'b0000;
            wdata_s   = 32'h0;
         end
      endcase
      ok_s        = access_s & aligned_s;
      err_s       = access_s & ~aligned_s;
      in_ram_s    = ({1'b0, bus.MEM_addr} < RAM_BYTES);
      in_mmio_s   = (bus.MEM_addr[31:4] == MMIO_BASE[31:4]);
      mmio_word_s = in_mmio_s & (size_s == SZ_W);
      ram_we_s    = ok_s & bus.MEM_wr_en & in_ram_s;
      tx_push_s   = ok_s & bus.MEM_wr_en & mmio_word_s & (bus.MEM_addr[3:0] == OFF_TX);
      ctrl_we_s   = ok_s & bus.MEM_wr_en & mmio_word_s & (bus.MEM_addr[3:0] == OFF_CTRL);
      idx_s       = bus.MEM_addr[AW+1:2];
      word_s      = ram_r[idx_s];
   end

   // STATUS image from the live FIFO state, so same-cycle pops are not seen.
   always_comb begin
      status_s                 = 32'h0;
      status_s[ST_FULL]        = fifo_full_s;
      status_s[ST_EMPTY]       = fifo_empty_s;
      status_s[ST_OVF]         = fifo_ovf_s;
      status_s[ST_CNT +: 5]    = 5'(fifo_count_s);
   end

   // Load mux: lanes right-justified and zero-extended; a store wins over a load.
   always_comb begin
      rdata_s = 32'h0;
      if (ok_s & bus.MEM_rd_en & ~bus.MEM_wr_en) begin
         if (in_ram_s) begin
            case (size_s)
               SZ_B:    rdata_s = {24'h0, 8'(word_s >> {bus.MEM_addr[1:0], 3'b000})};
               SZ_H:    rdata_s = {16'h0, 16'(word_s >> {bus.MEM_addr[1], 4'b0000})};
               SZ_W:    rdata_s = word_s;
               default: rdata_s = 32'h0;
            endcase
         end else if (mmio_word_s) begin
            case (bus.MEM_addr[3:0])
               OFF_STATUS: rdata_s = status_s;
               OFF_CYCLE:  rdata_s = cycle_r;
               default:    rdata_s = 32'h0;
            endcase
         end else begin
            rdata_s = 32'h0;
         end
      end else begin
         rdata_s = 32'h0;
      end
   end

   // Cycle counter (clear beats increment) and sticky misalignment flag.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cycle_r    <= 32'h0;
         misalign_r <= 1'b0;
      end else begin
         if (ctrl_we_s & bus.MEM_WR_out[0]) cycle_r <= 32'h0;
         else                               cycle_r <= cycle_r + 32'h1;
         if (err_s) misalign_r <= 1'b1;
      end
   end

   // RAM byte-lane writes; contents survive reset.
   always_ff @(posedge CLK) begin
      if (ram_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) ram_r[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
         end
      end
   end

   tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (CLK),
      .rst_n     (Reset),
      .push_req  (tx_push_s),
      .push_data (bus.MEM_WR_out[7:0]),
      .pop_ready (bus.tx_ready),
      .ovf_clr   (ctrl_we_s & bus.MEM_WR_out[1]),
      .head      (tx_head_s),
      .valid     (tx_valid_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s),
      .overflow  (fifo_ovf_s)
   );

   assign bus.MEM_data     = rdata_s;
   assign bus.tx_data      = tx_head_s;
   assign bus.tx_valid     = tx_valid_s;
   assign bus.misalign_err = misalign_r;
endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: a vector table for RAM/MMIO loads,
// plus hand sequences for misalignment, FIFO fill/drain, cycle counter and reset.
module tb_data_mem_unit;
   import mem_pkg::*;

   localparam logic [31:0] A_TX     = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0004;
   localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
   localparam logic [31:0] A_CTRL   = 32'h8000_000C;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  mt;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   logic CLK;
   logic Reset;
   int   total = 0;
   int   bad   = 0;
   vec_t        vecs[$];
   logic [31:0] rd_q[$];
   logic [7:0]  tx_q[$];

   data_mem_unit_if bus();
   data_mem_unit dut (.CLK(CLK), .Reset(Reset), .bus(bus));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drive one cycle; for loads, pop the scoreboard and compare before the edge.
   task automatic access(input logic rd, input logic wr, input logic [2:0] mt,
                         input logic [31:0] addr, input logic [31:0] wd, input string nm);
      logic [31:0] exp;
      bus.MEM_rd_en  = rd;
      bus.MEM_wr_en  = wr;
      bus.MEM_type   = mt;
      bus.MEM_addr   = addr;
      bus.MEM_WR_out = wd;
      #1;
      if (rd) begin
         if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got 0x%08h expected no load", nm, bus.MEM_data);
         end else begin
            exp = rd_q.pop_front();
            check(nm, bus.MEM_data, exp);
         end
      end
      @(posedge CLK); #1;
      bus.MEM_rd_en = 1'b0;
      bus.MEM_wr_en = 1'b0;
   endtask

   task automatic wr(input logic [2:0] mt, input logic [31:0] addr, input logic [31:0] wd);
      access(1'b0, 1'b1, mt, addr, wd, "wr");
   endtask

   task automatic rd(input logic [2:0] mt, input logic [31:0] addr, input logic [31:0] exp,
                     input string nm);
      rd_q.push_back(exp);
      access(1'b1, 1'b0, mt, addr, 32'h0, nm);
   endtask

   task automatic add(input logic r, input logic w, input logic [2:0] mt,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.rd = r; v.wr = w; v.mt = mt; v.addr = a; v.wd = d; v.exp = e;
      vecs.push_back(v);
   endtask

   // TX scoreboard: every accepted byte must match the next expected one.
   always @(negedge CLK) begin
      if (Reset && bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_extra: got 0x%02h expected no byte", bus.tx_data);
         end else begin
            check("tx_pop", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
         end
      end
   end

   initial begin
      Reset          = 1'b0;
      bus.MEM_addr   = 32'h0;
      bus.MEM_WR_out = 32'h0;
      bus.MEM_type   = MT_W;
      bus.MEM_rd_en  = 1'b0;
      bus.MEM_wr_en  = 1'b0;
      bus.tx_ready   = 1'b0;

      add(1'b0, 1'b1, MT_W,  32'h10,   32'hDEADBEEF, 32'h0);
      add(1'b1, 1'b0, MT_B,  32'h11,   32'h0,        32'h0000_00BE);
      add(1'b1, 1'b0, MT_BU, 32'h13,   32'h0,        32'h0000_00DE);
      add(1'b1, 1'b0, MT_H,  32'h12,   32'h0,        32'h0000_DEAD);
      add(1'b1, 1'b0, MT_W,  32'h10,   32'h0,        32'hDEADBEEF);
      add(1'b1, 1'b0, MT_HU, 32'h10,   32'h0,        32'h0000_BEEF);
      add(1'b0, 1'b1, MT_W,  32'h20,   32'h11223344, 32'h0);
      add(1'b0, 1'b1, MT_B,  32'h21,   32'hFFFFFF5A, 32'h0);
      add(1'b1, 1'b0, MT_W,  32'h20,   32'h0,        32'h11225A44);
      add(1'b0, 1'b1, MT_H,  32'h22,   32'hABCDBEEF, 32'h0);
      add(1'b1, 1'b0, MT_W,  32'h20,   32'h0,        32'hBEEF5A44);
      add(1'b1, 1'b1, MT_W,  32'h30,   32'hCAFEF00D, 32'h0);
      add(1'b1, 1'b0, MT_W,  32'h30,   32'h0,        32'hCAFEF00D);
      add(1'b0, 1'b1, MT_W,  32'h0,    32'h0BADF00D, 32'h0);
      add(1'b0, 1'b1, MT_W,  32'h1000, 32'h12345678, 32'h0);
      add(1'b1, 1'b0, MT_W,  32'h1000, 32'h0,        32'h0);
      add(1'b1, 1'b0, MT_W,  32'h0,    32'h0,        32'h0BADF00D);
      add(1'b0, 1'b1, MT_W,  32'hFFC,  32'h76543210, 32'h0);
      add(1'b1, 1'b0, MT_B,  32'hFFF,  32'h0,        32'h0000_0076);
      add(1'b1, 1'b0, MT_B,  A_STATUS, 32'h0,        32'h0);
      add(1'b1, 1'b0, MT_H,  A_CYCLE + 32'h2, 32'h0, 32'h0);
      add(1'b1, 1'b0, MT_W,  A_TX,     32'h0,        32'h0);
      add(1'b1, 1'b0, MT_W,  A_STATUS, 32'h0,        32'h0000_0002);
      add(1'b1, 1'b0, MT_W,  A_CTRL + 32'h10, 32'h0, 32'h0);

      // Reset state (comb read works while Reset is low).
      #2;
      check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      check("rst_misalign", {31'h0, bus.misalign_err}, 32'h0);
      rd(MT_W, A_STATUS, 32'h0000_0002, "rst_status");
      Reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rd) rd_q.push_back(vecs[i].exp);
         access(vecs[i].rd, vecs[i].wr, vecs[i].mt, vecs[i].addr, vecs[i].wd,
                $sformatf("vec%0d", i));
      end
      check("no_misalign", {31'h0, bus.misalign_err}, 32'h0);

      bus.MEM_type = MT_W; bus.MEM_addr = 32'h10; #1;
      check("rd_en_low", bus.MEM_data, 32'h0);
      @(posedge CLK); #1;

      // Misaligned accesses: no write, zero data, sticky flag from next cycle.
      wr(MT_W, 32'h04, 32'h13579BDF);
      bus.MEM_wr_en = 1'b1; bus.MEM_type = MT_H; bus.MEM_addr = 32'h03;
      bus.MEM_WR_out = 32'h0000FFFF; #1;
      check("mis_pre", {31'h0, bus.misalign_err}, 32'h0);
      @(posedge CLK); #1;
      bus.MEM_wr_en = 1'b0;
      check("mis_set", {31'h0, bus.misalign_err}, 32'h1);
      wr(MT_W, 32'h06, 32'hFFFFFFFF);
      rd(MT_W, 32'h06, 32'h0, "mis_rd");
      rd(MT_W, 32'h00, 32'h0BADF00D, "mis_w0");
      rd(MT_W, 32'h04, 32'h13579BDF, "mis_w1");
      repeat (5) @(posedge CLK);
      #1;
      check("mis_sticky", {31'h0, bus.misalign_err}, 32'h1);

      // Fill past full with the drain stalled.
      for (int k = 0; k < 5; k++) begin
         if (k < 4) tx_q.push_back(8'h41 + 8'(k));
         wr(MT_W, A_TX, 32'hFFFFFF41 + 32'(k));
      end
      rd(MT_W, A_STATUS, 32'h0000_0025, "st_full_ovf");
      check("tx_head", {24'h0, bus.tx_data}, 32'h41);
      check("tx_valid", {31'h0, bus.tx_valid}, 32'h1);
      repeat (2) @(posedge CLK);
      #1;
      check("tx_hold", {24'h0, bus.tx_data}, 32'h41);

      bus.tx_ready = 1'b1;
      rd(MT_W, A_STATUS, 32'h0000_0025, "st_prepop");
      repeat (3) @(posedge CLK);
      #1;
      bus.tx_ready = 1'b0;
      check("drain_valid", {31'h0, bus.tx_valid}, 32'h0);
      check("drain_left", 32'(tx_q.size()), 32'h0);
      rd(MT_W, A_STATUS, 32'h0000_0006, "st_empty_ovf");

      // Overflow clear, then push on full with a simultaneous pop.
      wr(MT_W, A_CTRL, 32'h2);
      rd(MT_W, A_STATUS, 32'h0000_0002, "st_ovf_clr");
      for (int k = 0; k < 4; k++) begin
         tx_q.push_back(8'h51 + 8'(k));
         wr(MT_W, A_TX, 32'h51 + 32'(k));
      end
      rd(MT_W, A_STATUS, 32'h0000_0021, "st_full");
      bus.tx_ready = 1'b1;
      tx_q.push_back(8'h99);
      wr(MT_W, A_TX, 32'h99);
      bus.tx_ready = 1'b0;
      rd(MT_W, A_STATUS, 32'h0000_0021, "st_push_pop");
      check("tx_head2", {24'h0, bus.tx_data}, 32'h52);
      bus.tx_ready = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      bus.tx_ready = 1'b0;
      check("drain2_valid", {31'h0, bus.tx_valid}, 32'h0);
      check("drain2_left", 32'(tx_q.size()), 32'h0);
      rd(MT_W, A_STATUS, 32'h0000_0002, "st_empty");

      // Cycle counter clear, read three cycles later.
      wr(MT_W, A_CTRL, 32'h1);
      repeat (3) @(posedge CLK);
      #1;
      rd(MT_W, A_CYCLE, 32'h3, "cycle3");

      // Asynchronous reset in the middle of a drain.
      for (int k = 0; k < 3; k++) begin
         tx_q.push_back(8'h61 + 8'(k));
         wr(MT_W, A_TX, 32'h61 + 32'(k));
      end
      bus.tx_ready = 1'b1;
      @(posedge CLK); #3;
      Reset = 1'b0;
      #1;
      check("rst_async_valid", {31'h0, bus.tx_valid}, 32'h0);
      check("rst_async_data", {24'h0, bus.tx_data}, 32'h0);
      tx_q.delete();
      bus.tx_ready = 1'b0;
      @(posedge CLK); #1;
      Reset = 1'b1;
      check("rst_mis_clr", {31'h0, bus.misalign_err}, 32'h0);
      rd(MT_W, A_STATUS, 32'h0000_0002, "rst_status2");
      rd(MT_W, 32'h10, 32'hDEADBEEF, "ram_keep0");
      rd(MT_W, 32'h20, 32'hBEEF5A44, "ram_keep1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
